// File: rtl/ddr_wr_arbiter.sv
// Two-port AXI4 write arbiter: one whole AW/W/B transaction owns the DDR master port at a time,
// round-robin between ports, with per-port completed-grant counters and sticky burst-length error flags.
module ddr_wr_arbiter #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 128
) (
  input  logic              aclk,
  input  logic              areset,

  input  logic [ADDR_W-1:0] s0_axi_awaddr,
  input  logic [7:0]        s0_axi_awlen,
  input  logic              s0_axi_awvalid,
  output logic              s0_axi_awready,
  input  logic [DATA_W-1:0] s0_axi_wdata,
  input  logic              s0_axi_wlast,
  input  logic              s0_axi_wvalid,
  output logic              s0_axi_wready,
  output logic [1:0]        s0_axi_bresp,
  output logic              s0_axi_bvalid,
  input  logic              s0_axi_bready,

  input  logic [ADDR_W-1:0] s1_axi_awaddr,
  input  logic [7:0]        s1_axi_awlen,
  input  logic              s1_axi_awvalid,
  output logic              s1_axi_awready,
  input  logic [DATA_W-1:0] s1_axi_wdata,
  input  logic              s1_axi_wlast,
  input  logic              s1_axi_wvalid,
  output logic              s1_axi_wready,
  output logic [1:0]        s1_axi_bresp,
  output logic              s1_axi_bvalid,
  input  logic              s1_axi_bready,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,

  output logic [1:0]        grant,
  output logic [1:0]        arb_state,
  output logic [31:0]       grant_count0,
  output logic [31:0]       grant_count1,
  output logic              len_err0,
  output logic              len_err1,
  input  logic              err_clear
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_AW = 2'd1, ST_W = 2'd2, ST_B = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        len_bad;
  logic        aw_hs, w_hs, b_hs;

  assign aw_hs = (state_q == ST_AW) & m_axi_awvalid & m_axi_awready;
  assign w_hs  = (state_q == ST_W)  & m_axi_wvalid  & m_axi_wready;
  assign b_hs  = (state_q == ST_B)  & m_axi_bvalid  & m_axi_bready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      rr_ptr_q   <= 1'b0;
      len_q      <= 8'd0;
      beat_cnt_q <= 9'd0;
      cnt0_q     <= 32'd0;
      cnt1_q     <= 32'd0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    len_bad    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s0_axi_awvalid | s1_axi_awvalid) begin
          if (s0_axi_awvalid & s1_axi_awvalid) grant_d = rr_ptr_q ? 2'b10 : 2'b01;
          else                                 grant_d = s1_axi_awvalid ? 2'b10 : 2'b01;
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        if (aw_hs) begin
          len_d      = m_axi_awlen;
          beat_cnt_d = 9'd0;
          state_d    = ST_W;
        end
      end
      ST_W: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          // beat_cnt_q counts beats already accepted, so the final beat arrives with it equal to awlen
          if (m_axi_wlast) begin
            len_bad = (beat_cnt_q != {1'b0, len_q});
            state_d = ST_B;
          end else begin
            len_bad = (beat_cnt_q == {1'b0, len_q});
          end
        end
      end
      ST_B: begin
        if (b_hs) begin
          if (grant_q[1]) cnt1_d = cnt1_q + 32'd1;
          else            cnt0_d = cnt0_q + 32'd1;
          rr_ptr_d = grant_q[0];
          grant_d  = 2'b00;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A same-cycle error set wins over err_clear
    err0_d = (len_bad & grant_q[0]) | (err0_q & ~err_clear);
    err1_d = (len_bad & grant_q[1]) | (err1_q & ~err_clear);
  end

  always_comb begin
    m_axi_awaddr   = '0;
    m_axi_awlen    = '0;
    m_axi_wdata    = '0;
    m_axi_awvalid  = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_wlast    = 1'b0;
    m_axi_bready   = 1'b0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    s0_axi_wready  = 1'b0;
    s1_axi_wready  = 1'b0;
    s0_axi_bvalid  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    s0_axi_bresp   = 2'b00;
    s1_axi_bresp   = 2'b00;
    if (grant_q[0]) begin
      m_axi_awaddr = s0_axi_awaddr;
      m_axi_awlen  = s0_axi_awlen;
      m_axi_wdata  = s0_axi_wdata;
    end else if (grant_q[1]) begin
      m_axi_awaddr = s1_axi_awaddr;
      m_axi_awlen  = s1_axi_awlen;
      m_axi_wdata  = s1_axi_wdata;
    end
    case (state_q)
      ST_AW: begin
        m_axi_awvalid  = (grant_q[0] & s0_axi_awvalid) | (grant_q[1] & s1_axi_awvalid);
        s0_axi_awready = m_axi_awready & grant_q[0];
        s1_axi_awready = m_axi_awready & grant_q[1];
      end
      ST_W: begin
        m_axi_wvalid  = (grant_q[0] & s0_axi_wvalid) | (grant_q[1] & s1_axi_wvalid);
        m_axi_wlast   = (grant_q[0] & s0_axi_wlast)  | (grant_q[1] & s1_axi_wlast);
        s0_axi_wready = m_axi_wready & grant_q[0];
        s1_axi_wready = m_axi_wready & grant_q[1];
      end
      ST_B: begin
        m_axi_bready  = (grant_q[0] & s0_axi_bready) | (grant_q[1] & s1_axi_bready);
        s0_axi_bvalid = m_axi_bvalid & grant_q[0];
        s1_axi_bvalid = m_axi_bvalid & grant_q[1];
        s0_axi_bresp  = grant_q[0] ? m_axi_bresp : 2'b00;
        s1_axi_bresp  = grant_q[1] ? m_axi_bresp : 2'b00;
      end
      default: ;
    endcase
  end

  assign grant        = grant_q;
  assign arb_state    = state_q;
  assign grant_count0 = cnt0_q;
  assign grant_count1 = cnt1_q;
  assign len_err0     = err0_q;
  assign len_err1     = err1_q;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed bench for ddr_wr_arbiter: the bench plays both DMA requesters and the DDR slave.
module tb_ddr_wr_arbiter;
  localparam int ADDR_W = 48;
  localparam int DATA_W = 128;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic              areset, err_clear;
  logic [ADDR_W-1:0] s_awaddr [2];
  logic [7:0]        s_awlen  [2];
  logic [DATA_W-1:0] s_wdata  [2];
  logic [1:0]        s_awvalid, s_wvalid, s_wlast, s_bready;
  wire  [1:0]        s_awready, s_wready, s_bvalid;
  wire  [1:0]        s0_bresp, s1_bresp;
  wire  [ADDR_W-1:0] m_awaddr;
  wire  [7:0]        m_awlen;
  wire               m_awvalid, m_wvalid, m_wlast, m_bready;
  wire  [DATA_W-1:0] m_wdata;
  logic              m_awready, m_wready, m_bvalid;
  logic [1:0]        m_bresp;
  wire  [1:0]        grant, arb_state;
  wire  [31:0]       gc0, gc1;
  wire               le0, le1;

  ddr_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .areset(areset),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]), .s0_axi_awvalid(s_awvalid[0]),
    .s0_axi_awready(s_awready[0]), .s0_axi_wdata(s_wdata[0]), .s0_axi_wlast(s_wlast[0]),
    .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s0_bresp),
    .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]), .s1_axi_awvalid(s_awvalid[1]),
    .s1_axi_awready(s_awready[1]), .s1_axi_wdata(s_wdata[1]), .s1_axi_wlast(s_wlast[1]),
    .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s1_bresp),
    .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]),
    .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .grant(grant), .arb_state(arb_state), .grant_count0(gc0), .grant_count1(gc1),
    .len_err0(le0), .len_err1(le1), .err_clear(err_clear)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int p, input int i);
    return {64'(p + 1), 32'hBEEF0000, 32'(i)};
  endfunction

  task automatic idle_inputs();
    s_awvalid = 2'b00; s_wvalid = 2'b00; s_wlast = 2'b00; s_bready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      s_awaddr[k] = '0; s_awlen[k] = '0; s_wdata[k] = '0;
    end
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    err_clear = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_state"}, arb_state, 2'd0);
    chk({tag, "_gc0"}, gc0, 0);
    chk({tag, "_gc1"}, gc1, 0);
    chk({tag, "_err"}, {le1, le0}, 2'b00);
    chk({tag, "_mvalid"}, {m_awvalid, m_wvalid, m_bready}, 3'b000);
    chk({tag, "_sready"}, {s_awready, s_wready, s_bvalid}, 6'b0);
  endtask

  // Serves one transaction from port p; the caller has already raised awvalid/awaddr/awlen.
  task automatic serve(input int p, input int nbeats, input bit bp, input int bdelay,
                       input logic [1:0] resp, input int exp_wait, input int rst_beat,
                       input bit clr_last);
    int         q    = 1 - p;
    int         cnt  = 0;
    int         rcv  = 0;
    int         cyc  = 0;
    int         bad  = 0;
    int         iso  = 0;
    logic [1:0] gexp = (p == 1) ? 2'b10 : 2'b01;
    while (grant == 2'b00 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("grant", grant, gexp);
    if (exp_wait >= 0) chk("arb_latency", cnt, exp_wait);

    m_awready = 1'b1;
    #1;
    chk("m_awaddr", m_awaddr, s_awaddr[p]);
    chk("m_awlen", m_awlen, s_awlen[p]);
    if (m_awvalid !== 1'b1 || s_awready[p] !== 1'b1 || s_awready[q] !== 1'b0) iso++;
    tick();
    m_awready = 1'b0;
    s_awvalid[p] = 1'b0;

    while (rcv < nbeats && cyc < 200) begin
      s_wvalid[p] = 1'b1;
      s_wdata[p]  = pat(p, rcv);
      s_wlast[p]  = (rcv == nbeats - 1);
      m_wready    = bp ? (cyc % 2 == 0) : 1'b1;
      err_clear   = clr_last && (rcv == nbeats - 1);
      #1;
      if (s_wready[q] !== 1'b0 || s_bvalid[q] !== 1'b0 || s_awready[q] !== 1'b0) iso++;
      if (rst_beat == rcv + 1) begin
        areset = 1'b1;
        tick();
        return;
      end
      if (m_wvalid !== 1'b1 || s_wready[p] !== m_wready) bad++;
      if (m_wvalid && m_wready) begin
        if (m_wdata !== pat(p, rcv) || m_wlast !== s_wlast[p]) bad++;
        rcv++;
      end
      tick();
      cyc++;
    end
    s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0; m_wready = 1'b0; err_clear = 1'b0;
    chk("beats", rcv, nbeats);
    chk("wdata", bad, 0);
    chk("state_b", arb_state, 2'd3);

    s_bready[p] = 1'b1;
    for (int d = 0; d < bdelay; d++) begin
      #1;
      if (s_bvalid[p] !== 1'b0 || s_bvalid[q] !== 1'b0 || m_bready !== 1'b1) iso++;
      tick();
    end
    m_bvalid = 1'b1;
    m_bresp  = resp;
    #1;
    chk("bvalid", s_bvalid[p], 1'b1);
    chk("bresp", (p == 1) ? s1_bresp : s0_bresp, resp);
    if (s_bvalid[q] !== 1'b0 || ((p == 1) ? s0_bresp : s1_bresp) !== 2'b00 || m_bready !== 1'b1) iso++;
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00; s_bready[p] = 1'b0;
    chk("isolation", iso, 0);
    chk("state_idle", arb_state, 2'd0);
    chk("grant_clr", grant, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    #1;
    chk_rst("reset");

    // single port 0 burst of 16 beats
    s_awaddr[0] = 48'h1000; s_awlen[0] = 8'd15; s_awvalid[0] = 1'b1;
    serve(0, 16, 1'b0, 0, 2'b00, 1, 0, 1'b0);
    chk("t1_gc0", gc0, 1);
    chk("t1_err0", le0, 0);

    // both ports requesting: strict alternation starting from port 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      s_awaddr[0] = 48'h2000 + 48'(k * 64); s_awlen[0] = 8'd3;
      s_awaddr[1] = 48'h3000 + 48'(k * 64); s_awlen[1] = 8'd3;
      s_awvalid = 2'b11;
      serve(k % 2, 4, 1'b0, 0, 2'b00, 1, 0, 1'b0);
    end
    s_awvalid = 2'b00;
    chk("t2_gc0", gc0, 2);
    chk("t2_gc1", gc1, 2);

    // toggling wready and a late B response
    s_awaddr[0] = 48'h4000; s_awlen[0] = 8'd7;
    s_awaddr[1] = 48'h5000; s_awlen[1] = 8'd3;
    s_awvalid = 2'b11;
    serve(0, 8, 1'b1, 10, 2'b00, 1, 0, 1'b0);
    serve(1, 4, 1'b1, 10, 2'b00, 1, 0, 1'b0);
    chk("t3_gc0", gc0, 3);
    chk("t3_gc1", gc1, 3);
    chk("t3_err", {le1, le0}, 2'b00);

    // early wlast on port 1
    s_awaddr[1] = 48'h6000; s_awlen[1] = 8'd7; s_awvalid[1] = 1'b1;
    serve(1, 4, 1'b0, 2, 2'b00, 1, 0, 1'b0);
    chk("t4_err1", le1, 1);
    chk("t4_err0", le0, 0);
    chk("t4_gc1", gc1, 4);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4_clear", le1, 0);

    // late wlast on port 0, SLVERR, clear pulsed together with the erroring beat
    s_awaddr[0] = 48'h7000; s_awlen[0] = 8'd1; s_awvalid[0] = 1'b1;
    serve(0, 3, 1'b0, 0, 2'b10, 1, 0, 1'b1);
    chk("t5_err0", le0, 1);
    chk("t5_gc0", gc0, 4);

    // reset during beat 5 of 16, then a fresh port 1 transaction
    s_awaddr[0] = 48'h8000; s_awlen[0] = 8'd15; s_awvalid[0] = 1'b1;
    serve(0, 16, 1'b0, 0, 2'b00, 1, 5, 1'b0);
    chk_rst("midw");
    areset = 1'b0;
    idle_inputs();
    s_awaddr[1] = 48'h9000; s_awlen[1] = 8'd3; s_awvalid[1] = 1'b1;
    serve(1, 4, 1'b0, 1, 2'b00, 1, 0, 1'b0);
    chk("t6_gc1", gc1, 1);
    chk("t6_gc0", gc0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
